phys_reg_read: RTL and testbench
================================

# phys_reg_read

Register-read stage on the consumer side of the 64-entry physical register file. It takes renamed instructions from dispatch and holds each one until both source tags are ready, tracked in a per-tag ready scoreboard. Operands come from the register file's read vector, with bypass from the two writeback ports that update the file on the same edge. Results go to execute through a valid/ready output register.

## Interface
Parameters:
- NUM_PREGS, 64, physical register count
- TAG_W, 6, physical tag width (log2 NUM_PREGS)
- DATA_W, 32, operand width
- ROB_W, 6, reorder-buffer index width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  global freeze; same signal that gates register-file writes
- flush  in  1  kill the instruction held in the output register
- alloc_valid  in  1  rename allocated a new destination tag this cycle
- alloc_tag  in  TAG_W  tag whose ready bit is cleared
- in_valid  in  1  dispatch offers an instruction
- in_ready  out  1  stage accepts it this cycle
- in_src1, in_src2, in_dst  in  TAG_W  source and destination tags
- in_rob  in  ROB_W  ROB index
- wb1_en, wb2_en  in  1  writeback port strobes (same as register-file update1/update2)
- wb1_tag, wb2_tag  in  TAG_W  writeback tags
- wb1_val, wb2_val  in  DATA_W  writeback data
- regs  in  DATA_W x NUM_PREGS  unpacked read vector from the register file
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute consumes
- out_op1, out_op2  out  DATA_W  resolved operands
- out_dst  out  TAG_W  registered destination tag
- out_rob  out  ROB_W  registered ROB index

## Operation
- Scoreboard rdy[NUM_PREGS]:
  - reset sets all bits to 1
  - wbN_en sets rdy[wbN_tag]
  - alloc_valid clears rdy[alloc_tag]
  - alloc and wb to the same tag in one cycle: alloc wins (bit cleared)
  - tag 0 always reads as ready
- src_ok(t) = (t==0) | rdy[t] | (wb1_en & wb1_tag==t) | (wb2_en & wb2_tag==t)
- in_ready = !stall & !flush & (!out_valid | out_ready) & src_ok(in_src1) & src_ok(in_src2). Combinational; no dependence on in_valid.
- Operand select, highest priority first:
  - tag 0 → 0
  - wb2 hit → wb2_val
  - wb1 hit → wb1_val
  - otherwise regs[t]
- Both wb ports hitting the same tag: wb2 wins, matching register-file write order.
- Accept (in_valid & in_ready): load the output register, out_valid=1.
- Hold: out_valid & !out_ready & !flush keeps all out_* unchanged.
- Drain without a new accept: out_valid & out_ready clears out_valid.
- stall=1: no state changes (scoreboard and output register frozen), in_ready=0, and wb/alloc inputs are ignored. The register file drops writes under stall, so the scoreboard must too.
- flush=1: clears out_valid next edge and has priority over stall and accept; the scoreboard is untouched.

## Timing
- Accept-to-out_valid latency: 1 cycle.
- Sustained throughput: 1 instruction/cycle when out_ready stays high.
- A wb on cycle N makes a dependent consumer acceptable in cycle N, with the value bypassed.
- An alloc on cycle N blocks consumers of that tag from cycle N+1; in cycle N the pre-alloc rdy value applies.
- Reset, asserted asynchronously:
  - out_valid=0
  - out_op1/out_op2/out_dst/out_rob = 0
  - rdy all 1
  - in_ready low while reset is asserted
- Reset mid-hold discards the held instruction.

## Structure
- Shared package `ooo_pkg`: NUM_PREGS, TAG_W, DATA_W, ROB_W, and the tag_t / data_t typedefs. The register file and rename use the same package.
- Sub-module `phys_ready_table`:
  - holds the scoreboard
  - ports: clk, reset, stall, alloc, two wb set ports, two combinational query ports returning src_ok with bypass
- Top level: operand muxes, output register, handshake.

## Test plan
- After reset, in_src1=5, in_src2=0, regs[5]=0x1234 → accepted; next cycle out_op1=0x1234, out_op2=0, out_valid=1.
- alloc_tag=9, then in_src1=9 → in_ready=0. Same cycle as wb1_en (tag 9, val 0xCAFE) → accepted, out_op1=0xCAFE.
- wb1 and wb2 both target tag 7 (0x1, 0x2), consumer of tag 7 → out_op1=0x2.
- out_valid=1, out_ready=0 for 3 cycles → out_* stable, in_ready=0; out_ready=1 with a queued instruction → back-to-back transfer.
- stall=1 with wb1_en to an allocated tag 12 → rdy[12] stays 0, outputs frozen. Deassert stall and repeat the wb → rdy[12]=1.
- flush with stall=1 and out_valid=1 → out_valid=0 next edge. Reset asserted mid-cycle → out_valid drops immediately, rdy all 1.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared sizing and types for the physical register file, rename and register-read stages.
package ooo_pkg;
   localparam int NUM_PREGS = 64;
   localparam int TAG_W     = 6;
   localparam int DATA_W    = 32;
   localparam int ROB_W     = 6;

   typedef logic [TAG_W-1:0]  tag_t;
   typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/phys_ready_table.sv
// Per-tag ready scoreboard with same-cycle writeback bypass on two query ports.
module phys_ready_table
   import ooo_pkg::*;
#(
   parameter int NPREGS = NUM_PREGS,
   parameter int TW     = TAG_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          alloc_valid,
   input  logic [TW-1:0] alloc_tag,
   input  logic          wb1_en,
   input  logic [TW-1:0] wb1_tag,
   input  logic          wb2_en,
   input  logic [TW-1:0] wb2_tag,
   input  logic [TW-1:0] q1_tag,
   output logic          q1_ok,
   input  logic [TW-1:0] q2_tag,
   output logic          q2_ok
);

   logic [NPREGS-1:0] rdy_q;
   logic [NPREGS-1:0] rdy_d;

   // Alloc is applied after the writeback sets so it wins on a shared tag.
   always_comb begin
      rdy_d = rdy_q;
      if (!stall) begin
         if (wb1_en)      rdy_d[wb1_tag]   = 1'b1;
         if (wb2_en)      rdy_d[wb2_tag]   = 1'b1;
         if (alloc_valid) rdy_d[alloc_tag] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rdy_q <= '1;
      else       rdy_q <= rdy_d;
   end

   always_comb begin
      q1_ok = (q1_tag == '0) | rdy_q[q1_tag]
            | (wb1_en & (wb1_tag == q1_tag)) | (wb2_en & (wb2_tag == q1_tag));
      q2_ok = (q2_tag == '0) | rdy_q[q2_tag]
            | (wb1_en & (wb1_tag == q2_tag)) | (wb2_en & (wb2_tag == q2_tag));
   end

endmodule

// File: rtl/phys_reg_read.sv
// Register-read stage: waits on source readiness, resolves operands with bypass, registers to execute.
module phys_reg_read #(
   parameter int NUM_PREGS = ooo_pkg::NUM_PREGS,
   parameter int TAG_W     = ooo_pkg::TAG_W,
   parameter int DATA_W    = ooo_pkg::DATA_W,
   parameter int ROB_W     = ooo_pkg::ROB_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              alloc_valid,
   input  logic [TAG_W-1:0]  alloc_tag,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [TAG_W-1:0]  in_src1,
   input  logic [TAG_W-1:0]  in_src2,
   input  logic [TAG_W-1:0]  in_dst,
   input  logic [ROB_W-1:0]  in_rob,
   input  logic              wb1_en,
   input  logic [TAG_W-1:0]  wb1_tag,
   input  logic [DATA_W-1:0] wb1_val,
   input  logic              wb2_en,
   input  logic [TAG_W-1:0]  wb2_tag,
   input  logic [DATA_W-1:0] wb2_val,
   input  logic [DATA_W-1:0] regs [NUM_PREGS],
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2,
   output logic [TAG_W-1:0]  out_dst,
   output logic [ROB_W-1:0]  out_rob
);

   logic              src1_ok, src2_ok, accept;
   logic [DATA_W-1:0] op1_sel, op2_sel;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_op1_q, out_op1_d;
   logic [DATA_W-1:0] out_op2_q, out_op2_d;
   logic [TAG_W-1:0]  out_dst_q, out_dst_d;
   logic [ROB_W-1:0]  out_rob_q, out_rob_d;

   phys_ready_table #(
      .NPREGS (NUM_PREGS),
      .TW     (TAG_W)
   ) u_rdy (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .alloc_valid (alloc_valid),
      .alloc_tag   (alloc_tag),
      .wb1_en      (wb1_en),
      .wb1_tag     (wb1_tag),
      .wb2_en      (wb2_en),
      .wb2_tag     (wb2_tag),
      .q1_tag      (in_src1),
      .q1_ok       (src1_ok),
      .q2_tag      (in_src2),
      .q2_ok       (src2_ok)
   );

   // wb2 is checked before wb1 to mirror register-file write order.
   function automatic logic [DATA_W-1:0] pick(input logic [TAG_W-1:0] t);
      if (t == '0)                    return '0;
      else if (wb2_en && wb2_tag == t) return wb2_val;
      else if (wb1_en && wb1_tag == t) return wb1_val;
      else                             return regs[t];
   endfunction

   always_comb begin
      op1_sel  = pick(in_src1);
      op2_sel  = pick(in_src2);
      in_ready = !reset && !stall && !flush && (!out_valid_q || out_ready)
                 && src1_ok && src2_ok;
      accept   = in_valid && in_ready;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_op1_d   = out_op1_q;
      out_op2_d   = out_op2_q;
      out_dst_d   = out_dst_q;
      out_rob_d   = out_rob_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (!stall) begin
         if (accept) begin
            out_valid_d = 1'b1;
            out_op1_d   = op1_sel;
            out_op2_d   = op2_sel;
            out_dst_d   = in_dst;
            out_rob_d   = in_rob;
         end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_op1_q   <= '0;
         out_op2_q   <= '0;
         out_dst_q   <= '0;
         out_rob_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_op1_q   <= out_op1_d;
         out_op2_q   <= out_op2_d;
         out_dst_q   <= out_dst_d;
         out_rob_q   <= out_rob_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_op1   = out_op1_q;
   assign out_op2   = out_op2_q;
   assign out_dst   = out_dst_q;
   assign out_rob   = out_rob_q;

endmodule

// File: tb/tb_phys_reg_read.sv
// Directed bench for phys_reg_read: readiness, bypass priority, hold/drain, stall, flush and reset.
module tb_phys_reg_read;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic        alloc_valid;
   logic [5:0]  alloc_tag;
   logic        in_valid, in_ready;
   logic [5:0]  in_src1, in_src2, in_dst;
   logic [5:0]  in_rob;
   logic        wb1_en, wb2_en;
   logic [5:0]  wb1_tag, wb2_tag;
   logic [31:0] wb1_val, wb2_val;
   logic [31:0] regs [64];
   logic        out_valid, out_ready;
   logic [31:0] out_op1, out_op2;
   logic [5:0]  out_dst, out_rob;

   int n_tests = 0;
   int n_fail  = 0;

   phys_reg_read dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush       (flush),
      .alloc_valid (alloc_valid),
      .alloc_tag   (alloc_tag),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_src1     (in_src1),
      .in_src2     (in_src2),
      .in_dst      (in_dst),
      .in_rob      (in_rob),
      .wb1_en      (wb1_en),
      .wb1_tag     (wb1_tag),
      .wb1_val     (wb1_val),
      .wb2_en      (wb2_en),
      .wb2_tag     (wb2_tag),
      .wb2_val     (wb2_val),
      .regs        (regs),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_op1     (out_op1),
      .out_op2     (out_op2),
      .out_dst     (out_dst),
      .out_rob     (out_rob)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] s1, input logic [5:0] s2,
                        input logic [5:0] d, input logic [5:0] r);
      in_valid = 1'b1;
      in_src1  = s1;
      in_src2  = s2;
      in_dst   = d;
      in_rob   = r;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) regs[i] = 32'(i) * 32'h0101;
      regs[0] = 32'hDEAD;
      regs[5] = 32'h1234;
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      alloc_valid = 1'b0; alloc_tag = '0;
      in_valid = 1'b0; in_src1 = '0; in_src2 = '0; in_dst = '0; in_rob = '0;
      wb1_en = 1'b0; wb1_tag = '0; wb1_val = '0;
      wb2_en = 1'b0; wb2_tag = '0; wb2_val = '0;
      out_ready = 1'b0;
      #1;
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      tick(); tick();
      reset = 1'b0;
      #1;
      check("rst_op1", out_op1, 32'd0);
      check("rst_dst", {26'b0, out_dst}, 32'd0);

      // Basic accept: tag 5 from regs, tag 0 forced to zero
      issue(6'd5, 6'd0, 6'd3, 6'd1);
      #1;
      check("t1_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      check("t1_valid", {31'b0, out_valid}, 32'd1);
      check("t1_op1", out_op1, 32'h1234);
      check("t1_op2", out_op2, 32'd0);
      check("t1_dst", {26'b0, out_dst}, 32'd3);
      check("t1_rob", {26'b0, out_rob}, 32'd1);
      out_ready = 1'b1;
      tick();
      check("t1_drain", {31'b0, out_valid}, 32'd0);

      // Alloc tag 9: same-cycle consumer sees pre-alloc state, then blocked, then bypass via wb1
      alloc_valid = 1'b1; alloc_tag = 6'd9; in_src1 = 6'd9; in_src2 = 6'd0;
      #1;
      check("t2_prealloc", {31'b0, in_ready}, 32'd1);
      tick();
      alloc_valid = 1'b0;
      #1;
      check("t2_blocked", {31'b0, in_ready}, 32'd0);
      issue(6'd9, 6'd0, 6'd10, 6'd2);
      wb1_en = 1'b1; wb1_tag = 6'd9; wb1_val = 32'hCAFE;
      #1;
      check("t2_wb_ready", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0; wb1_en = 1'b0;
      check("t2_valid", {31'b0, out_valid}, 32'd1);
      check("t2_op1", out_op1, 32'hCAFE);
      tick();
      check("t2_drain", {31'b0, out_valid}, 32'd0);

      // Both writeback ports on tag 7: wb2 wins
      issue(6'd7, 6'd5, 6'd15, 6'd3);
      wb1_en = 1'b1; wb1_tag = 6'd7; wb1_val = 32'h1;
      wb2_en = 1'b1; wb2_tag = 6'd7; wb2_val = 32'h2;
      tick();
      in_valid = 1'b0; wb1_en = 1'b0; wb2_en = 1'b0;
      check("t3_op1", out_op1, 32'h2);
      check("t3_op2", out_op2, 32'h1234);

      // Hold for 3 cycles with a queued instruction, then back-to-back transfer
      out_ready = 1'b0;
      issue(6'd5, 6'd0, 6'd20, 6'd5);
      #1;
      check("t4_hold_in_ready", {31'b0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_hold_valid", {31'b0, out_valid}, 32'd1);
         check("t4_hold_op1", out_op1, 32'h2);
         check("t4_hold_dst", {26'b0, out_dst}, 32'd15);
         check("t4_hold_rob", {26'b0, out_rob}, 32'd3);
      end
      out_ready = 1'b1;
      #1;
      check("t4_release_ready", {31'b0, in_ready}, 32'd1);
      tick();
      check("t4_b2b_valid", {31'b0, out_valid}, 32'd1);
      check("t4_b2b_dst", {26'b0, out_dst}, 32'd20);
      check("t4_b2b_op1", out_op1, 32'h1234);
      issue(6'd0, 6'd5, 6'd21, 6'd6);
      tick();
      in_valid = 1'b0;
      check("t4_thru_dst", {26'b0, out_dst}, 32'd21);
      check("t4_thru_op2", out_op2, 32'h1234);
      check("t4_thru_op1", out_op1, 32'd0);
      tick();
      check("t4_drain", {31'b0, out_valid}, 32'd0);

      // Stall freezes the scoreboard and output register
      out_ready = 1'b0;
      alloc_valid = 1'b1; alloc_tag = 6'd12;
      issue(6'd5, 6'd0, 6'd30, 6'd7);
      tick();
      alloc_valid = 1'b0; in_valid = 1'b0;
      check("t5_loaded", {26'b0, out_dst}, 32'd30);
      stall = 1'b1; out_ready = 1'b1;
      wb1_en = 1'b1; wb1_tag = 6'd12; wb1_val = 32'hBEEF;
      in_src1 = 6'd12; in_src2 = 6'd0;
      #1;
      check("t5_stall_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      check("t5_frozen_valid", {31'b0, out_valid}, 32'd1);
      check("t5_frozen_dst", {26'b0, out_dst}, 32'd30);
      stall = 1'b0; wb1_en = 1'b0;
      #1;
      check("t5_rdy12_still0", {31'b0, in_ready}, 32'd0);
      wb1_en = 1'b1;
      tick();
      wb1_en = 1'b0;
      #1;
      check("t5_rdy12_set", {31'b0, in_ready}, 32'd1);

      // Alloc beats writeback on the same tag
      alloc_valid = 1'b1; alloc_tag = 6'd44;
      wb2_en = 1'b1; wb2_tag = 6'd44; wb2_val = 32'h44;
      in_src1 = 6'd0;
      tick();
      alloc_valid = 1'b0; wb2_en = 1'b0; in_src1 = 6'd44;
      #1;
      check("t6_alloc_wins", {31'b0, in_ready}, 32'd0);

      // Flush under stall clears the held instruction
      issue(6'd12, 6'd0, 6'd40, 6'd8);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t7_loaded_op1", out_op1, 32'h0C0C);
      stall = 1'b1; flush = 1'b1; out_ready = 1'b0;
      #1;
      check("t7_flush_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      check("t7_flushed", {31'b0, out_valid}, 32'd0);
      stall = 1'b0; flush = 1'b0;

      // Asynchronous reset mid-hold
      alloc_valid = 1'b1; alloc_tag = 6'd33;
      issue(6'd5, 6'd0, 6'd50, 6'd9);
      tick();
      alloc_valid = 1'b0; in_valid = 1'b0; in_src1 = 6'd33;
      check("t8_loaded", {31'b0, out_valid}, 32'd1);
      #1;
      check("t8_rdy33_clear", {31'b0, in_ready}, 32'd0);
      #1;
      reset = 1'b1;
      #1;
      check("t8_rst_valid", {31'b0, out_valid}, 32'd0);
      check("t8_rst_op1", out_op1, 32'd0);
      check("t8_rst_dst", {26'b0, out_dst}, 32'd0);
      check("t8_rst_in_ready", {31'b0, in_ready}, 32'd0);
      reset = 1'b0;
      #1;
      check("t8_rdy_all1", {31'b0, in_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
